// File: rtl/ftq_pc_mem_banked_v2.sv
// FTQ PC memory: NUM_ENTRIES x {startAddr, nextLineAddr, fallThruError} with per-entry
// valid bits, NUM_RPORTS independent 1-cycle read ports, write->read bypass and flush.
module ftq_pc_mem_banked_v2 #(
    parameter int NUM_ENTRIES = 64,
    parameter int VADDR_W     = 39,
    parameter int NUM_RPORTS  = 5,
    localparam int PTR_W      = $clog2(NUM_ENTRIES)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_RPORTS-1:0]         io_ren,
    input  logic [NUM_RPORTS*PTR_W-1:0]   io_raddr,
    output logic [NUM_RPORTS*VADDR_W-1:0] io_rdata_startAddr,
    output logic [NUM_RPORTS*VADDR_W-1:0] io_rdata_nextLineAddr,
    output logic [NUM_RPORTS-1:0]         io_rdata_fallThruError,
    output logic [NUM_RPORTS-1:0]         io_rvalid,
    input  logic                          io_wen,
    input  logic [PTR_W-1:0]              io_waddr,
    input  logic [VADDR_W-1:0]            io_wdata_startAddr,
    input  logic [VADDR_W-1:0]            io_wdata_nextLineAddr,
    input  logic                          io_wdata_fallThruError,
    input  logic                          io_flush,
    output logic [PTR_W:0]                io_valid_count
);
    localparam int ENTRY_W = 2*VADDR_W + 1;

    logic [ENTRY_W-1:0]     r_mem [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] r_valid;
    logic [PTR_W:0]         r_valid_count;

    logic [ENTRY_W-1:0]     w_wentry;
    logic                   w_wr_new;
    logic [NUM_ENTRIES-1:0] w_wr_onehot;

    assign w_wentry    = {io_wdata_startAddr, io_wdata_nextLineAddr, io_wdata_fallThruError};
    assign w_wr_new    = io_wen & ~r_valid[io_waddr];
    assign w_wr_onehot = {{(NUM_ENTRIES-1){1'b0}}, 1'b1} << io_waddr;

    // Data array carries no reset; writes are still blocked while reset is held.
    always_ff @(posedge clock) begin
        if (io_wen && reset) begin
            r_mem[io_waddr] <= w_wentry;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid       <= '0;
            r_valid_count <= '0;
        end else if (io_flush) begin
            // A same-cycle write survives the flush.
            r_valid       <= io_wen ? w_wr_onehot : '0;
            r_valid_count <= io_wen ? {{PTR_W{1'b0}}, 1'b1} : '0;
        end else if (io_wen) begin
            r_valid[io_waddr] <= 1'b1;
            r_valid_count     <= r_valid_count + {{PTR_W{1'b0}}, w_wr_new};
        end
    end

    assign io_valid_count = r_valid_count;

    generate
        for (genvar gi = 0; gi < NUM_RPORTS; gi++) begin : g_rport
            logic [PTR_W-1:0]   w_raddr;
            logic               w_hit;
            logic [ENTRY_W-1:0] r_rdata;
            logic               r_rvalid;

            assign w_raddr = io_raddr[gi*PTR_W +: PTR_W];
            assign w_hit   = io_wen && (io_waddr == w_raddr);

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_rdata  <= '0;
                    r_rvalid <= 1'b0;
                end else if (io_ren[gi]) begin
                    if (w_hit) begin
                        r_rdata  <= w_wentry;
                        r_rvalid <= 1'b1;
                    end else begin
                        r_rdata  <= r_mem[w_raddr];
                        r_rvalid <= r_valid[w_raddr] & ~io_flush;
                    end
                end
            end

            assign io_rdata_startAddr[gi*VADDR_W +: VADDR_W]    = r_rdata[ENTRY_W-1 -: VADDR_W];
            assign io_rdata_nextLineAddr[gi*VADDR_W +: VADDR_W] = r_rdata[VADDR_W -: VADDR_W];
            assign io_rdata_fallThruError[gi]                   = r_rdata[0];
            assign io_rvalid[gi]                                = r_rvalid;
        end
    endgenerate

endmodule

// File: doc/ftq_pc_mem_banked_v2.md
FTQ_PC_MEM_BANKED_V2 -- requirements
Module: ftq_pc_mem_banked_v2

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 64, FTQ depth (power of two, >=4); PTR_W = log2(NUM_ENTRIES).
REQ-002 SHALL have parameter VADDR_W, default 39, virtual address width.
REQ-003 SHALL have parameter NUM_RPORTS, default 5, number of read ports (>=1).
REQ-004 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port io_ren  input  NUM_RPORTS  per-port read enable.
REQ-007 SHALL have port io_raddr  input  NUM_RPORTS*PTR_W  packed read pointers; port i at bits [i*PTR_W +: PTR_W].
REQ-008 SHALL have port io_rdata_startAddr  output  NUM_RPORTS*VADDR_W  packed read startAddr.
REQ-009 SHALL have port io_rdata_nextLineAddr  output  NUM_RPORTS*VADDR_W  packed read nextLineAddr.
REQ-010 SHALL have port io_rdata_fallThruError  output  NUM_RPORTS  per-port fallThruError.
REQ-011 SHALL have port io_rvalid  output  NUM_RPORTS  per-port entry-valid flag of the returned data.
REQ-012 SHALL have port io_wen  input  1  write enable.
REQ-013 SHALL have port io_waddr  input  PTR_W  write pointer.
REQ-014 SHALL have ports io_wdata_startAddr / io_wdata_nextLineAddr  input  VADDR_W each, and io_wdata_fallThruError  input  1.
REQ-015 SHALL have port io_flush  input  1  invalidate all entries.
REQ-016 SHALL have port io_valid_count  output  PTR_W+1  number of currently valid entries.

Function
REQ-017 SHALL store NUM_ENTRIES entries of {startAddr, nextLineAddr, fallThruError} plus one valid bit per entry; data array not reset.
REQ-018 SHALL perform writes at the rising edge when io_wen=1: entry[io_waddr] <= wdata, valid[io_waddr] <= 1.
REQ-019 SHALL give read latency of exactly 1 cycle: io_ren[i]=1 in cycle N -> port i outputs entry[io_raddr_i] and valid bit in cycle N+1.
REQ-020 SHALL hold port i outputs unchanged in any cycle following io_ren[i]=0.
REQ-021 SHALL bypass write to read: io_wen=1 and io_ren[i]=1 with io_waddr==io_raddr_i in cycle N -> cycle N+1 returns the new write data with io_rvalid[i]=1.
REQ-022 SHALL, on io_flush=1, clear every valid bit at the edge; array data retained.
REQ-023 SHALL let write win over flush for io_waddr in the same cycle: that entry ends valid=1, all others 0.
REQ-024 SHALL return io_rvalid[i]=0 for a read issued in the same cycle as io_flush, unless bypassed per REQ-021/REQ-023.
REQ-025 SHALL serve all NUM_RPORTS reads independently and concurrently; identical addresses on multiple ports permitted.
REQ-026 SHALL update io_valid_count registered: +1 when writing an invalid entry, unchanged when rewriting a valid entry; after flush equals 1 if same-cycle write else 0; range 0..NUM_ENTRIES.
REQ-027 SHALL treat io_raddr/io_waddr modulo NUM_ENTRIES (pointer wrap handled by caller; no out-of-range case).

Reset
REQ-028 SHALL, while reset=0, asynchronously force all valid bits 0, io_valid_count 0, all io_rdata_* 0 and io_rvalid 0.
REQ-029 SHALL ignore io_wen, io_ren, io_flush while reset=0; first write accepted on the first rising edge with reset=1.
REQ-030 SHALL, if reset asserts mid-operation, discard in-flight reads (outputs 0 next observation), no partial update.

Verification
REQ-031 SHALL cover basic R/W: write entry 3 {0x1000,0x1040,1}; next cycle ren[0]=1 raddr 3 -> following cycle startAddr 0x1000, nextLineAddr 0x1040, fte 1, rvalid 1; count 1.
REQ-032 SHALL cover bypass: same cycle wen addr 7 data 0x2000 and ren[2] raddr 7 (entry held 0x1111) -> next cycle port 2 startAddr 0x2000, rvalid 1.
REQ-033 SHALL cover flush+write: entries 0..63 valid, flush with wen addr 5 -> count 1; read 5 rvalid 1, read 6 rvalid 0 with old data.
REQ-034 SHALL cover full/wrap: write all 64 entries -> count 64; rewrite entry 0 -> count stays 64; five ports reading 0,63,63,1,2 all correct in one cycle.
REQ-035 SHALL cover hold and reset: ren=0 for 3 cycles keeps outputs stable; assert reset mid-stream -> outputs and count 0 immediately without clock edge.
